expr_lane_pipe: RTL and testbench



---
 rtl/expr_lane_pipe.sv | 167 ++++++++++++++++
 tb/tb_expr_lane_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/expr_lane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : expr_lane_pipe
//  Description : Two-stage valid/ready pipeline evaluating one of eight
//                arithmetic/logic operators per lane, each lane with fixed
//                signedness. Operands are extended to 2W bits in stage 1 and
//                results are registered in stage 2. Also keeps a wrapping
//                output-handshake counter and a sticky divide-by-zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module expr_lane_pipe #(
    parameter int               W           = 6,
    parameter int               LANES       = 3,
    parameter logic [LANES-1:0] SIGNED_MASK = LANES'(3'b101)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W*LANES-1:0]       in_a,
    input  logic [W*LANES-1:0]       in_b,
    input  logic [3*LANES-1:0]       in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W*LANES-1:0]     out_y,
    output logic [15:0]              txn_count,
    output logic                     div0,
    input  logic                     clear
);

    localparam int R  = 2 * W;
    localparam int SW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_LT  = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_XNR = 3'd6;

    // Stage 1 holds extended operands; stage 2 holds results.
    logic                   s1_valid_q;
    logic [R*LANES-1:0]     s1_a_q;
    logic [R*LANES-1:0]     s1_b_q;
    logic [3*LANES-1:0]     s1_op_q;
    logic                   out_valid_q;
    logic [R*LANES-1:0]     out_y_q;
    logic [15:0]            txn_count_q;
    logic                   div0_q;

    logic [R*LANES-1:0]     a_ext_d;
    logic [R*LANES-1:0]     b_ext_d;
    logic [R*LANES-1:0]     y_d;
    logic [LANES-1:0]       dz_d;

    logic                   w_s1_advance;
    logic                   w_accept;

    assign w_s1_advance = !out_valid_q || out_ready;
    assign in_ready     = !s1_valid_q || w_s1_advance;
    assign w_accept     = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign txn_count = txn_count_q;
    assign div0      = div0_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam bit IS_SIGNED = SIGNED_MASK[i];

        logic [W-1:0]  a_raw;
        logic [W-1:0]  b_raw;
        logic [R-1:0]  a;
        logic [R-1:0]  b;
        logic [2:0]    op;
        logic [SW-1:0] sh;
        logic [R-1:0]  y;
        logic          dz;

        assign a_raw = in_a[i*W +: W];
        assign b_raw = in_b[i*W +: W];
        assign a_ext_d[i*R +: R] = IS_SIGNED ? {{W{a_raw[W-1]}}, a_raw} : {{W{1'b0}}, a_raw};
        assign b_ext_d[i*R +: R] = IS_SIGNED ? {{W{b_raw[W-1]}}, b_raw} : {{W{1'b0}}, b_raw};

        assign a  = s1_a_q[i*R +: R];
        assign b  = s1_b_q[i*R +: R];
        assign op = s1_op_q[i*3 +: 3];
        // Low bits of the extended B equal the original B bits.
        assign sh = b[SW-1:0];

        // Per-lane operator evaluation on the stage-1 operands.
        always_comb begin
            y  = '0;
            dz = 1'b0;
            case (op)
                OP_ADD: y = a + b;
                OP_SUB: y = a - b;
                // Product of two W-bit operands always fits in 2W bits.
                OP_MUL: y = a * b;
                OP_LT: begin
                    if (IS_SIGNED) y[0] = ($signed(a) < $signed(b));
                    else           y[0] = (a < b);
                end
                OP_EQ:  y[0] = (a == b);
                OP_SHR: begin
                    if (IS_SIGNED) y = $signed(a) >>> sh;
                    else           y = a >> sh;
                end
                OP_XNR: y[0] = ~^a[W-1:0];
                default: begin
                    if (b == '0) begin
                        y  = '1;
                        dz = 1'b1;
                    end else if (IS_SIGNED) begin
                        y = $signed(a) / $signed(b);
                    end else begin
                        y = a / b;
                    end
                end
            endcase
        end

        assign y_d[i*R +: R] = y;
        assign dz_d[i]       = dz;
    end

    // Stage 1: capture extended operands on an input handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= a_ext_d;
                s1_b_q     <= b_ext_d;
                s1_op_q    <= in_op;
            end else if (w_s1_advance) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    // Stage 2: register results; out_y only changes when new data arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
        end else if (w_s1_advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_y_q <= y_d;
        end
    end

    // Handshake counter and sticky div0 flag; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            txn_count_q <= '0;
            div0_q      <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) txn_count_q <= txn_count_q + 16'd1;
            if (w_s1_advance && s1_valid_q && (|dz_d)) div0_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expr_lane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_lane_pipe
//  Description : Directed self-checking bench for expr_lane_pipe
//                (W=6, LANES=3, lanes 0 and 2 signed, lane 1 unsigned).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_expr_lane_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic [8:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_y;
    logic [15:0] txn_count;
    logic        div0;
    logic        clear;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    expr_lane_pipe #(.W(6), .LANES(3), .SIGNED_MASK(3'b101)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .txn_count (txn_count),
        .div0      (div0),
        .clear     (clear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, check 2-cycle latency and result, let it drain.
    task automatic send_one(input string tag, input logic [17:0] a, input logic [17:0] b,
                            input logic [8:0] op, input logic [35:0] exp);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_v1"}, out_valid, 0);
        tick();
        chk({tag, "_v2"}, out_valid, 1);
        chk({tag, "_y"}, out_y, exp);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          recv;
        int          c;
        int          hs;
        int          acc;
        int          cyc;
        bit          prev_stall;
        bit          seen;
        logic [35:0] prev_y;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b1; clear = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_y", out_y, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_div0", div0, 0);
        reset = 1'b0;
        tick();

        // Add on all lanes
        send_one("add", {6'h20, 6'h3B, 6'h3B}, {6'h3F, 6'h03, 6'h03}, {3'd0, 3'd0, 3'd0},
                 {12'hFDF, 12'h03E, 12'hFFE});
        chk("add_txn", txn_count, 1);

        // Mul / div / divide by zero
        send_one("muldiv", {6'h39, 6'h3F, 6'h20}, {6'h02, 6'h00, 6'h20}, {3'd7, 3'd7, 3'd2},
                 {12'hFFD, 12'hFFF, 12'h400});
        chk("div0_set", div0, 1);
        tick(); tick(); tick();
        chk("div0_sticky", div0, 1);
        chk("muldiv_txn", txn_count, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_div0", div0, 0);
        chk("clr_txn", txn_count, 0);

        // Signedness-dependent operators
        send_one("lt_xnor", {6'h07, 6'h3F, 6'h3F}, {6'h00, 6'h01, 6'h01}, {3'd6, 3'd3, 3'd3},
                 {12'h000, 12'h000, 12'h001});
        send_one("shr", {6'h20, 6'h20, 6'h20}, {6'h02, 6'h02, 6'h02}, {3'd5, 3'd5, 3'd5},
                 {12'hFF8, 12'h008, 12'hFF8});
        send_one("sub_eq", {6'h05, 6'h03, 6'h03}, {6'h05, 6'h05, 6'h05}, {3'd4, 3'd1, 3'd1},
                 {12'h001, 12'hFFE, 12'hFFE});
        send_one("div_xnor", {6'h00, 6'h3F, 6'h20}, {6'h00, 6'h04, 6'h3F}, {3'd6, 3'd7, 3'd7},
                 {12'h001, 12'h00F, 12'h020});
        send_one("mul_add", {6'h3F, 6'h3F, 6'h1F}, {6'h05, 6'h3F, 6'h01}, {3'd2, 3'd2, 3'd0},
                 {12'hFFB, 12'hF81, 12'h020});
        chk("nodiv0", div0, 0);

        // Backpressure stream of 10 transactions, out_ready low for cycles 3..7
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sent = 0; recv = 0; c = 0; prev_stall = 1'b0; prev_y = '0;
        while (recv < 10 && c < 100) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (sent < 10);
            in_a      = {3{6'(sent)}};
            in_b      = {3{6'd1}};
            in_op     = '0;
            #1;
            if (c == 5) chk("bp_full_in_ready", in_ready, 0);
            if (c == 8) chk("bp_release_in_ready", in_ready, 1);
            if (prev_stall) chk("bp_hold_y", out_y, prev_y);
            if (out_valid && out_ready) begin
                chk("bp_y", out_y, {3{12'(recv + 1)}});
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            if (in_valid && in_ready) sent++;
            c++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_recv", recv, 10);
        chk("bp_sent", sent, 10);
        chk("bp_txn", txn_count, 10);
        tick();
        chk("bp_empty", out_valid, 0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_a  = {6'd0, 6'd1, 6'd0};
        in_b  = '0;
        in_op = {3'd0, 3'd7, 3'd0};
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_div0", div0, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_txn", txn_count, 0);
        chk("mid_rst_div0", div0, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;
        send_one("post_rst", {6'd1, 6'd2, 6'd3}, {6'd4, 6'd5, 6'd6}, {3'd0, 3'd0, 3'd0},
                 {12'h005, 12'h007, 12'h009});
        chk("post_rst_txn", txn_count, 1);
        chk("post_rst_empty", out_valid, 0);

        // Wrap of the handshake counter
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        hs = 0; acc = 0; cyc = 0; seen = 1'b0;
        while (hs < 65537 && cyc < 70000) begin
            in_valid = (acc < 65537);
            #1;
            if (out_valid && out_ready) hs++;
            if (in_valid && in_ready) acc++;
            cyc++;
            tick();
            if (hs == 65535 && !seen) begin
                seen = 1'b1;
                chk("wrap_ffff", txn_count, 16'hFFFF);
            end
        end
        in_valid = 1'b0;
        chk("wrap_hs", hs, 65537);
        chk("wrap_txn", txn_count, 1);

        // Output handshake and clear in the same cycle
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("hsclr_valid", out_valid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("hsclr_txn", txn_count, 0);
        chk("hsclr_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
